motor_pwm_capture: RTL and testbench

//   Three-channel PWM input capture; the receive-side counterpart of the motor PWM generator.

---
 rtl/motor_pwm_pkg.sv | 15 +
 rtl/motor_pwm_capture_channel.sv | 139 +++++++++++++
 rtl/motor_pwm_capture.sv | 78 +++++++
 tb/tb_motor_pwm_capture.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// rtl/motor_pwm_pkg.sv - shared types and defaults for the PWM capture block
package motor_pwm_pkg;

  localparam int unsigned SIZE_DEFAULT        = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Per-channel capture state: IDLE while disabled, ARM until the first
  // rising edge starts a period, MEAS while a period is being counted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } cap_state_e;

endpackage

// File: rtl/motor_pwm_capture_channel.sv
// rtl/motor_pwm_capture_channel.sv - one PWM input capture channel
//
// Synchronizes one asynchronous PWM input, detects rising edges and measures
// the rising-to-rising period and the high time inside it, in clk_i cycles.
//
// Ports:
//   clk_i      system clock (posedge)
//   rst_ni     asynchronous active-low reset
//   enable_i   low forces IDLE and discards any partial measurement
//   timeout_i  stall limit in cycles, 0 disables the stall detector
//   pwm_i      asynchronous PWM input
//   period_o   last measured period
//   high_o     high cycles within that period
//   valid_o    one-cycle pulse, period_o/high_o updated
//   stall_o    level, no rising edge within timeout_i cycles
module motor_pwm_capture_channel
  import motor_pwm_pkg::*;
#(
  parameter int unsigned SIZE        = SIZE_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic [SIZE-1:0] timeout_i,
  input  logic            pwm_i,
  output logic [SIZE-1:0] period_o,
  output logic [SIZE-1:0] high_o,
  output logic            valid_o,
  output logic            stall_o
);

  localparam logic [SIZE-1:0] CNT_MAX = '1;
  localparam logic [SIZE-1:0] CNT_ONE = SIZE'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;

  cap_state_e      state_q,  state_d;
  logic [SIZE-1:0] cnt_q,    cnt_d;
  logic [SIZE-1:0] hi_q,     hi_d;
  logic [SIZE-1:0] period_q, period_d;
  logic [SIZE-1:0] high_q,   high_d;
  logic            valid_q,  valid_d;
  logic            stall_q,  stall_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      s_d_q    <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;

    if (!enable_i) begin
      // Disable wins from any state; measured values are kept, stall is not.
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = '0;
      stall_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          hi_d    = '0;
          stall_d = 1'b0;
        end
        ARM: begin
          // The rise cycle itself is the first cycle of the period and is high.
          if (rise) begin
            cnt_d   = CNT_ONE;
            hi_d    = CNT_ONE;
            state_d = MEAS;
          end
        end
        MEAS: begin
          // A rise on the same cycle the limit is reached still completes the
          // period, so the rise branch is tested before the timeout.
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_q;
            valid_d  = 1'b1;
            stall_d  = 1'b0;
            cnt_d    = CNT_ONE;
            hi_d     = CNT_ONE;
          end else if ((timeout_i != '0) && (cnt_q >= timeout_i)) begin
            stall_d  = 1'b1;
            period_d = '0;
            high_d   = '0;
            cnt_d    = '0;
            hi_d     = '0;
            state_d  = ARM;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            hi_d  = (s && (hi_q != CNT_MAX)) ? hi_q + CNT_ONE : hi_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign stall_o  = stall_q;

endmodule

// File: rtl/motor_pwm_capture.sv
// rtl/motor_pwm_capture.sv - three-channel PWM input capture top level
//
// Three independent capture channels sharing clock, reset, enable and the
// stall limit. Each reports period and high time of its PWM input in iCLK
// cycles, a one-cycle valid pulse per completed period, and a stall level.
//
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iENABLE               low holds all channels IDLE
//   iTIMEOUT              stall limit in cycles, 0 disables
//   iPWM_A/B/C            asynchronous PWM inputs
//   oPERIOD_x, oHIGH_x    last period and its high time
//   oVALID_x              one-cycle update pulse
//   oSTALL_x              no rising edge within iTIMEOUT cycles
module motor_pwm_capture
  import motor_pwm_pkg::*;
#(
  parameter int unsigned SIZE        = SIZE_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iENABLE,
  input  logic [SIZE-1:0] iTIMEOUT,
  input  logic            iPWM_A,
  input  logic            iPWM_B,
  input  logic            iPWM_C,
  output logic [SIZE-1:0] oPERIOD_A,
  output logic [SIZE-1:0] oHIGH_A,
  output logic            oVALID_A,
  output logic            oSTALL_A,
  output logic [SIZE-1:0] oPERIOD_B,
  output logic [SIZE-1:0] oHIGH_B,
  output logic            oVALID_B,
  output logic            oSTALL_B,
  output logic [SIZE-1:0] oPERIOD_C,
  output logic [SIZE-1:0] oHIGH_C,
  output logic            oVALID_C,
  output logic            oSTALL_C
);

  motor_pwm_capture_channel #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) u_ch_a (
    .clk_i    (iCLK),
    .rst_ni   (iRST_N),
    .enable_i (iENABLE),
    .timeout_i(iTIMEOUT),
    .pwm_i    (iPWM_A),
    .period_o (oPERIOD_A),
    .high_o   (oHIGH_A),
    .valid_o  (oVALID_A),
    .stall_o  (oSTALL_A)
  );

  motor_pwm_capture_channel #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) u_ch_b (
    .clk_i    (iCLK),
    .rst_ni   (iRST_N),
    .enable_i (iENABLE),
    .timeout_i(iTIMEOUT),
    .pwm_i    (iPWM_B),
    .period_o (oPERIOD_B),
    .high_o   (oHIGH_B),
    .valid_o  (oVALID_B),
    .stall_o  (oSTALL_B)
  );

  motor_pwm_capture_channel #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) u_ch_c (
    .clk_i    (iCLK),
    .rst_ni   (iRST_N),
    .enable_i (iENABLE),
    .timeout_i(iTIMEOUT),
    .pwm_i    (iPWM_C),
    .period_o (oPERIOD_C),
    .high_o   (oHIGH_C),
    .valid_o  (oVALID_C),
    .stall_o  (oSTALL_C)
  );

endmodule

// File: tb/tb_motor_pwm_capture.sv
// tb/tb_motor_pwm_capture.sv - scoreboard bench for motor_pwm_capture
`timescale 1ns/1ps
module tb_motor_pwm_capture;

  localparam int LAT = 3;  // pin change to registered output, SYNC_STAGES + 1

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b0;
  logic [15:0] to   = '0;
  logic [7:0] to8   = '0;
  logic [3:0] pin   = '0;
  logic       zero  = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] per_a, hi_a, per_b, hi_b, per_c, hi_c;
  logic        vld_a, stl_a, vld_b, stl_b, vld_c, stl_c;
  logic [7:0]  per8_a, hi8_a, per8_b, hi8_b, per8_c, hi8_c;
  logic        vld8_a, stl8_a, vld8_b, stl8_b, vld8_c, stl8_c;

  motor_pwm_capture dut (
    .iCLK(clk), .iRST_N(rst_n), .iENABLE(ena), .iTIMEOUT(to),
    .iPWM_A(pin[0]), .iPWM_B(pin[1]), .iPWM_C(pin[2]),
    .oPERIOD_A(per_a), .oHIGH_A(hi_a), .oVALID_A(vld_a), .oSTALL_A(stl_a),
    .oPERIOD_B(per_b), .oHIGH_B(hi_b), .oVALID_B(vld_b), .oSTALL_B(stl_b),
    .oPERIOD_C(per_c), .oHIGH_C(hi_c), .oVALID_C(vld_c), .oSTALL_C(stl_c)
  );

  motor_pwm_capture #(.SIZE(8)) dut8 (
    .iCLK(clk), .iRST_N(rst_n), .iENABLE(ena), .iTIMEOUT(to8),
    .iPWM_A(pin[3]), .iPWM_B(zero), .iPWM_C(zero),
    .oPERIOD_A(per8_a), .oHIGH_A(hi8_a), .oVALID_A(vld8_a), .oSTALL_A(stl8_a),
    .oPERIOD_B(per8_b), .oHIGH_B(hi8_b), .oVALID_B(vld8_b), .oSTALL_B(stl8_b),
    .oPERIOD_C(per8_c), .oHIGH_C(hi8_c), .oVALID_C(vld8_c), .oSTALL_C(stl8_c)
  );

  // Channels 0..2 = A/B/C of dut, channel 3 = A of the 8-bit dut8.
  int gen_per[4];
  int gen_hi[4];
  int ph[4];
  bit gen_on[4];
  bit meas[4];
  int since[4];
  int hic[4];
  int last_rise[4];
  int arm_cyc[4];
  int vcount[4];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$], q1[$], q2[$], q3[$];

  function automatic void qpush(input int c, input logic [31:0] v);
    case (c)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int c);
    case (c)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [31:0] qpop(input int c);
    case (c)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      gen_on[c] = 1'b0;
      meas[c]   = 1'b0;
      pin[c]    = 1'b0;
    end
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic start_gen(input int c, input int per, input int hi);
    gen_per[c] = per;
    gen_hi[c]  = hi;
    ph[c]      = 0;
    gen_on[c]  = 1'b1;
  endtask

  // Each cycle: compare any valid against the scoreboard, then drive the next
  // pin values and push the expected measurement of every completed period.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      for (int c = 0; c < 4; c++) begin
        logic        v;
        logic [31:0] got;
        logic [31:0] exp_v;
        bit          np;
        int          mx;
        int          tv;
        case (c)
          0: begin v = vld_a; got = {per_a, hi_a}; end
          1: begin v = vld_b; got = {per_b, hi_b}; end
          2: begin v = vld_c; got = {per_c, hi_c}; end
          default: begin v = vld8_a; got = {8'd0, per8_a, 8'd0, hi8_a}; end
        endcase
        if (v === 1'b1) begin
          vcount[c]++;
          checks++;
          if (qsize(c) == 0) begin
            errors++;
            $display("FAIL sb_ch%0d unexpected valid: got period=%0d high=%0d, required no valid",
                     c, got[31:16], got[15:0]);
          end else begin
            exp_v = qpop(c);
            if (got !== exp_v) begin
              errors++;
              $display("FAIL sb_ch%0d got period=%0d high=%0d required period=%0d high=%0d",
                       c, got[31:16], got[15:0], exp_v[31:16], exp_v[15:0]);
            end
          end
        end
        mx = (c == 3) ? 255 : 65535;
        tv = (c == 3) ? int'(to8) : int'(to);
        np = gen_on[c] && (ph[c] < gen_hi[c]);
        if (gen_on[c]) ph[c] = (ph[c] + 1) % gen_per[c];
        if (!ena || !rst_n) begin
          meas[c] = 1'b0;
        end else if (np && !pin[c]) begin
          if (meas[c]) qpush(c, {16'(since[c]), 16'(hic[c])});
          else arm_cyc[c] = cyc;
          meas[c]      = 1'b1;
          since[c]     = 1;
          hic[c]       = 1;
          last_rise[c] = cyc;
        end else if (meas[c] && tv != 0 && since[c] >= tv) begin
          meas[c] = 1'b0;
        end else if (meas[c]) begin
          since[c] = (since[c] < mx) ? since[c] + 1 : mx;
          hic[c]   = (np && hic[c] < mx) ? hic[c] + 1 : hic[c];
        end
        pin[c] = np;
      end
    end
  endtask

  task automatic test_reset();
    clear_model();
    run_cycles(3);
    checks++;
    if ({per_a, hi_a, vld_a, stl_a} !== '0) begin
      errors++; $display("FAIL reset_a got %h required 0", {per_a, hi_a, vld_a, stl_a});
    end
    checks++;
    if ({per_b, hi_b, vld_b, stl_b} !== '0) begin
      errors++; $display("FAIL reset_b got %h required 0", {per_b, hi_b, vld_b, stl_b});
    end
    checks++;
    if ({per_c, hi_c, vld_c, stl_c} !== '0) begin
      errors++; $display("FAIL reset_c got %h required 0", {per_c, hi_c, vld_c, stl_c});
    end
    checks++;
    if ({per8_a, hi8_a, vld8_a, stl8_a, per8_b, hi8_b, vld8_b, stl8_b,
         per8_c, hi8_c, vld8_c, stl8_c} !== '0) begin
      errors++; $display("FAIL reset_dut8 got nonzero outputs required 0");
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    run_cycles(3);
  endtask

  task automatic test_square();
    int n = 0;
    to = 16'd0;
    start_gen(0, 8, 3);
    while (vld_a !== 1'b1 && n < 40) begin run_cycles(1); n++; end
    checks++;
    if (vld_a !== 1'b1) begin
      errors++; $display("FAIL square_first_valid got no valid required valid within 40 cycles");
    end else if (cyc != arm_cyc[0] + 8 + LAT) begin
      errors++; $display("FAIL square_first_valid got cycle %0d required %0d", cyc, arm_cyc[0] + 8 + LAT);
    end
    while (cyc < arm_cyc[0] + 32) run_cycles(1);
    gen_on[0] = 1'b0;
    run_cycles(6);
    checks++;
    if (vcount[0] != 4) begin
      errors++; $display("FAIL square_count got %0d valids required 4", vcount[0]);
    end
    checks++;
    if ({per_a, hi_a} !== {16'd8, 16'd3}) begin
      errors++; $display("FAIL square_hold got %0d/%0d required 8/3", per_a, hi_a);
    end
    checks++;
    if (q0.size() != 0) begin
      errors++; $display("FAIL square_drain got %0d pending required 0", q0.size());
    end
  endtask

  task automatic test_duty();
    int n = 0;
    int v1 = vcount[1];
    int v2 = vcount[2];
    to = 16'd30;
    start_gen(1, 8, 1);
    start_gen(2, 10, 4);
    run_cycles(40);
    gen_hi[1] = 7;
    run_cycles(40);
    gen_hi[1] = 0;
    while (stl_b !== 1'b1 && n < 60) begin run_cycles(1); n++; end
    checks++;
    if (stl_b !== 1'b1) begin
      errors++; $display("FAIL duty_stall_b got 0 required 1 within 60 cycles");
    end else if (cyc != last_rise[1] + 30 + LAT) begin
      errors++; $display("FAIL duty_stall_b got cycle %0d required %0d", cyc, last_rise[1] + 30 + LAT);
    end
    checks++;
    if ({per_b, hi_b} !== 32'd0) begin
      errors++; $display("FAIL duty_stall_vals got %0d/%0d required 0/0", per_b, hi_b);
    end
    gen_on[1] = 1'b0;
    gen_on[2] = 1'b0;
    run_cycles(6);
    checks++;
    if ({per_c, hi_c} !== {16'd10, 16'd4}) begin
      errors++; $display("FAIL duty_c got %0d/%0d required 10/4", per_c, hi_c);
    end
    checks++;
    if (vcount[1] - v1 != 9 || vcount[2] - v2 < 8) begin
      errors++; $display("FAIL duty_count got b=%0d c=%0d required b=9 c>=8", vcount[1] - v1, vcount[2] - v2);
    end
    checks++;
    if (q1.size() + q2.size() != 0) begin
      errors++; $display("FAIL duty_drain got %0d pending required 0", q1.size() + q2.size());
    end
  endtask

  task automatic test_timeout();
    int  n = 0;
    logic prev;
    to = 16'd20;
    start_gen(0, 8, 3);
    run_cycles(32);
    gen_on[0] = 1'b0;
    checks++;
    if (stl_a !== 1'b0) begin
      errors++; $display("FAIL timeout_cleared got %b required 0", stl_a);
    end
    while (stl_a !== 1'b1 && n < 40) begin run_cycles(1); n++; end
    checks++;
    if (stl_a !== 1'b1) begin
      errors++; $display("FAIL timeout_stall got 0 required 1 within 40 cycles");
    end else if (cyc != last_rise[0] + 20 + LAT) begin
      errors++; $display("FAIL timeout_stall got cycle %0d required %0d", cyc, last_rise[0] + 20 + LAT);
    end
    checks++;
    if ({per_a, hi_a} !== 32'd0) begin
      errors++; $display("FAIL timeout_vals got %0d/%0d required 0/0", per_a, hi_a);
    end
    start_gen(0, 8, 3);
    n = 0;
    prev = stl_a;
    while (vld_a !== 1'b1 && n < 30) begin prev = stl_a; run_cycles(1); n++; end
    checks++;
    if (prev !== 1'b1 || stl_a !== 1'b0) begin
      errors++; $display("FAIL timeout_resume got stall %b->%b required 1->0", prev, stl_a);
    end
    gen_on[0] = 1'b0;
    run_cycles(6);
    checks++;
    if (q0.size() != 0) begin
      errors++; $display("FAIL timeout_drain got %0d pending required 0", q0.size());
    end
  endtask

  task automatic test_saturate();
    bit saw = 1'b0;
    int v3  = vcount[3];
    to = 16'd0;
    start_gen(3, 300, 100);
    for (int i = 0; i < 901; i++) begin run_cycles(1); saw |= stl8_a; end
    gen_on[3] = 1'b0;
    run_cycles(6);
    checks++;
    if (saw) begin
      errors++; $display("FAIL sat_stall got 1 required 0");
    end
    checks++;
    if ({per8_a, hi8_a} !== {8'd255, 8'd100} || vcount[3] - v3 != 3) begin
      errors++; $display("FAIL sat_vals got %0d/%0d count %0d required 255/100 count 3",
                         per8_a, hi8_a, vcount[3] - v3);
    end
    checks++;
    if (q3.size() != 0) begin
      errors++; $display("FAIL sat_drain got %0d pending required 0", q3.size());
    end
  endtask

  task automatic test_enable();
    int n = 0;
    int v0;
    to = 16'd0;
    start_gen(0, 8, 3);
    run_cycles(28);
    gen_on[0] = 1'b0;
    run_cycles(3);
    ena = 1'b0;
    v0  = vcount[0];
    run_cycles(10);
    checks++;
    if ({per_a, hi_a} !== {16'd8, 16'd3} || stl_a !== 1'b0 || vcount[0] != v0) begin
      errors++; $display("FAIL enable_idle got %0d/%0d stall %b valids %0d required 8/3 stall 0 valids 0",
                         per_a, hi_a, stl_a, vcount[0] - v0);
    end
    ena = 1'b1;
    run_cycles(3);
    start_gen(0, 8, 3);
    while (vld_a !== 1'b1 && n < 30) begin run_cycles(1); n++; end
    checks++;
    if (vld_a !== 1'b1 || cyc != arm_cyc[0] + 8 + LAT) begin
      errors++; $display("FAIL enable_rearm got valid %b at cycle %0d required 1 at %0d",
                         vld_a, cyc, arm_cyc[0] + 8 + LAT);
    end
    gen_on[0] = 1'b0;
    run_cycles(6);
    checks++;
    if (q0.size() != 0) begin
      errors++; $display("FAIL enable_drain got %0d pending required 0", q0.size());
    end
  endtask

  task automatic test_async_reset();
    start_gen(0, 8, 3);
    run_cycles(20);
    checks++;
    if ({per_a, hi_a} !== {16'd8, 16'd3}) begin
      errors++; $display("FAIL areset_pre got %0d/%0d required 8/3", per_a, hi_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({per_a, hi_a, vld_a, stl_a, per_b, hi_b, vld_b, stl_b, per_c, hi_c, vld_c, stl_c} !== '0) begin
      errors++; $display("FAIL areset_outputs got nonzero required 0 (a=%0d/%0d)", per_a, hi_a);
    end
    checks++;
    if ({per8_a, hi8_a, stl8_a, per8_b, hi8_b, stl8_b, per8_c, hi8_c, stl8_c} !== '0) begin
      errors++; $display("FAIL areset_dut8 got %0d/%0d required 0/0", per8_a, hi8_a);
    end
    clear_model();
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(3);
  endtask

  task automatic test_tie();
    bit saw = 1'b0;
    int v0  = vcount[0];
    to = 16'd8;
    start_gen(0, 8, 3);
    for (int i = 0; i < 41; i++) begin run_cycles(1); saw |= stl_a; end
    gen_on[0] = 1'b0;
    run_cycles(6);
    checks++;
    if (saw || vcount[0] - v0 != 5) begin
      errors++; $display("FAIL tie_rise_wins got stall %b valids %0d required stall 0 valids 5",
                         saw, vcount[0] - v0);
    end
    checks++;
    if (q0.size() != 0) begin
      errors++; $display("FAIL tie_drain got %0d pending required 0", q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_duty();
    test_timeout();
    test_saturate();
    test_enable();
    test_async_reset();
    test_tie();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
